// File: rtl/wave_tally_pkg.sv
// Shared types and constants for the invaders wave logic: FSM states,
// playfield geometry and the per-row point values.
package invaders_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int ALIEN_ROWS = 5;
    localparam int ALIEN_COLS = 11;

    localparam int ROW_W    = 3;
    localparam int POINTS_W = 6;
    localparam int SCORE_W  = 11;
    localparam int ALIENS_W = 6;

    localparam logic [SCORE_W-1:0]  MAX_WAVE_SCORE = 11'd1100;
    localparam logic [ALIENS_W-1:0] WAVE_ALIENS    = ALIENS_W'(ALIEN_ROWS * ALIEN_COLS);

    localparam logic [POINTS_W-1:0] POINTS_TOP    = 6'd30;
    localparam logic [POINTS_W-1:0] POINTS_MID    = 6'd20;
    localparam logic [POINTS_W-1:0] POINTS_BOTTOM = 6'd10;

endpackage

// File: rtl/wave_tally_if.sv
// Bundle of the wave controls coming from the game core and the wave
// results going to the score display / accumulator.
interface wave_tally_if;
    import invaders_pkg::*;

    logic                start;
    logic                kill;
    logic [ROW_W-1:0]    kill_row;
    logic                lose;
    logic [SCORE_W-1:0]  wave_score;
    logic [ALIENS_W-1:0] aliens_left;
    logic                win;
    logic                active;

    // Game core side: issues events, observes the wave state.
    modport master (
        output start, kill, kill_row, lose,
        input  wave_score, aliens_left, win, active
    );

    // Wave tally side: consumes events, reports the wave state.
    modport slave (
        input  start, kill, kill_row, lose,
        output wave_score, aliens_left, win, active
    );

endinterface

// File: rtl/wave_tally_row_points.sv
// Row-to-points lookup. Rows 5..7 do not exist on the playfield, so they
// report zero points with the valid flag low.
module row_points
    import invaders_pkg::*;
(
    input  logic [ROW_W-1:0]    i_row,
    output logic [POINTS_W-1:0] o_points,
    output logic                o_valid
);

    // Top row is worth the most, bottom row the least.
    always_comb begin
        o_points = '0;
        o_valid  = 1'b0;
        case (i_row)
            3'd0: begin
                o_points = POINTS_TOP;
                o_valid  = 1'b1;
            end
            3'd1, 3'd2, 3'd3: begin
                o_points = POINTS_MID;
                o_valid  = 1'b1;
            end
            3'd4: begin
                o_points = POINTS_BOTTOM;
                o_valid  = 1'b1;
            end
            default: begin
                o_points = '0;
                o_valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wave_tally.sv
// Per-wave score and alien tally. A Moore FSM tracks one wave from start to
// either clear (one-cycle win pulse carrying the final score) or loss.
module wave_tally
    import invaders_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    wave_tally_if.slave  bus
);

    state_t              r_state;
    logic [SCORE_W-1:0]  r_score;
    logic [ALIENS_W-1:0] r_aliens;
    logic                r_win;
    logic                r_active;

    logic [POINTS_W-1:0] w_points;
    logic                w_rowValid;
    logic                w_killOk;
    logic [SCORE_W:0]    w_sum;
    logic [SCORE_W-1:0]  w_scoreNext;

    row_points u_rowPoints (
        .i_row    (bus.kill_row),
        .o_points (w_points),
        .o_valid  (w_rowValid)
    );

    // A kill only counts for a real row while aliens remain; the score adds
    // one bit wider so saturation can be detected instead of wrapping.
    always_comb begin
        w_killOk    = bus.kill && w_rowValid && (r_aliens != '0);
        w_sum       = {1'b0, r_score} + {{(SCORE_W + 1 - POINTS_W){1'b0}}, w_points};
        w_scoreNext = (w_sum > {1'b0, MAX_WAVE_SCORE}) ? MAX_WAVE_SCORE : w_sum[SCORE_W-1:0];
    end

    // Wave FSM with registered outputs; a kill is scored before lose is
    // considered, so a last-alien kill wins even when lose arrives with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_score  <= '0;
            r_aliens <= '0;
            r_win    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_win <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        r_state  <= ST_PLAY;
                        r_score  <= '0;
                        r_aliens <= WAVE_ALIENS;
                        r_active <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_killOk) begin
                        r_score  <= w_scoreNext;
                        r_aliens <= r_aliens - 1'b1;
                    end
                    if (w_killOk && (r_aliens == 6'd1)) begin
                        r_state  <= ST_WIN;
                        r_win    <= 1'b1;
                        r_active <= 1'b0;
                    end else if (bus.lose) begin
                        r_state  <= ST_OVER;
                        r_active <= 1'b0;
                    end
                end
                ST_WIN: begin
                    r_state <= ST_IDLE;
                    r_score <= '0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wave_score  = r_score;
    assign bus.aliens_left = r_aliens;
    assign bus.win         = r_win;
    assign bus.active      = r_active;

endmodule

// File: tb/tb_wave_tally.sv
// Testbench for wave_tally: directed scenarios followed by random play,
// all compared against a wave-level behavioural model.
module tb_wave_tally;

    logic clk;
    logic reset_n;

    wave_tally_if bus ();

    wave_tally dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { M_IDLE, M_PLAY, M_WON, M_OVER } mode_t;

    mode_t modelMode;
    int    modelScore;
    int    modelAliens;
    int    errors;
    int    checks;

    // Points an alien in a given row is worth; zero for rows off the field.
    function automatic int pointsFor(input int row);
        if (row == 0) return 30;
        if (row >= 1 && row <= 3) return 20;
        if (row == 4) return 10;
        return 0;
    endfunction

    // Advance the wave model by one clock edge using the wave rules.
    task automatic modelStep(input bit rstN, input bit st, input bit kl, input int row, input bit ls);
        if (!rstN) begin
            modelMode   = M_IDLE;
            modelScore  = 0;
            modelAliens = 0;
        end else begin
            case (modelMode)
                M_IDLE, M_OVER: begin
                    if (st) begin
                        modelMode   = M_PLAY;
                        modelScore  = 0;
                        modelAliens = 55;
                    end
                end
                M_PLAY: begin
                    if (kl && pointsFor(row) > 0 && modelAliens > 0) begin
                        modelScore  = modelScore + pointsFor(row);
                        if (modelScore > 1100) modelScore = 1100;
                        modelAliens = modelAliens - 1;
                        if (modelAliens == 0) modelMode = M_WON;
                        else if (ls) modelMode = M_OVER;
                    end else if (ls) begin
                        modelMode = M_OVER;
                    end
                end
                M_WON: begin
                    modelMode  = M_IDLE;
                    modelScore = 0;
                end
                default: modelMode = M_IDLE;
            endcase
        end
    endtask

    // Compare one observed value with a value the bench worked out itself.
    task automatic expectValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic checkOutput(input string tag);
        expectValue({tag, ".wave_score"}, int'(bus.wave_score), modelScore);
        expectValue({tag, ".aliens_left"}, int'(bus.aliens_left), modelAliens);
        expectValue({tag, ".win"}, int'(bus.win), (modelMode == M_WON) ? 1 : 0);
        expectValue({tag, ".active"}, int'(bus.active), (modelMode == M_PLAY) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, clock it, update the model, check outputs.
    task automatic applyStimulus(input string tag, input bit rstN, input bit st,
                                 input bit kl, input int row, input bit ls);
        reset_n      = rstN;
        bus.start    = st;
        bus.kill     = kl;
        bus.kill_row = 3'(row);
        bus.lose     = ls;
        @(posedge clk);
        modelStep(rstN, st, kl, row, ls);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int winCount;
        errors       = 0;
        checks       = 0;
        modelMode    = M_IDLE;
        modelScore   = 0;
        modelAliens  = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.kill_row = 3'd0;
        bus.lose     = 1'b0;
        @(negedge clk);

        $display("[TB] reset and start");
        applyStimulus("reset0", 0, 0, 0, 0, 0);
        applyStimulus("reset1", 0, 1, 1, 0, 1);
        expectValue("resetActive", int'(bus.active), 0);
        applyStimulus("start", 1, 1, 0, 0, 0);
        expectValue("startAliens", int'(bus.aliens_left), 55);
        expectValue("startActive", int'(bus.active), 1);

        $display("[TB] row 0/2/4 kills");
        applyStimulus("killRow0", 1, 0, 1, 0, 0);
        expectValue("scoreAfterRow0", int'(bus.wave_score), 30);
        applyStimulus("killRow2", 1, 0, 1, 2, 0);
        expectValue("scoreAfterRow2", int'(bus.wave_score), 50);
        applyStimulus("killRow4", 1, 0, 1, 4, 0);
        expectValue("scoreAfterRow4", int'(bus.wave_score), 60);
        expectValue("aliensAfter3", int'(bus.aliens_left), 52);
        applyStimulus("startInPlay", 1, 1, 0, 0, 0);

        $display("[TB] full clear");
        applyStimulus("resetFull", 0, 0, 0, 0, 0);
        applyStimulus("startFull", 1, 1, 0, 0, 0);
        winCount = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 11; c++) begin
                applyStimulus("clearKill", 1, 0, 1, r, 0);
                winCount += int'(bus.win);
            end
        end
        expectValue("winScore", int'(bus.wave_score), 1100);
        expectValue("winAliens", int'(bus.aliens_left), 0);
        expectValue("winPulse", int'(bus.win), 1);
        applyStimulus("afterWin", 1, 1, 0, 0, 0);
        winCount += int'(bus.win);
        expectValue("winCount", winCount, 1);
        expectValue("afterWinScore", int'(bus.wave_score), 0);
        expectValue("afterWinActive", int'(bus.active), 0);

        $display("[TB] lose with kill");
        applyStimulus("startLose", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("row1Kill", 1, 0, 1, 1, 0);
        expectValue("scoreBeforeLose", int'(bus.wave_score), 60);
        applyStimulus("killAndLose", 1, 0, 1, 1, 1);
        expectValue("loseScore", int'(bus.wave_score), 80);
        expectValue("loseActive", int'(bus.active), 0);
        expectValue("loseWin", int'(bus.win), 0);
        applyStimulus("overHold", 1, 0, 1, 0, 1);
        expectValue("overFrozenScore", int'(bus.wave_score), 80);
        applyStimulus("startAndLose", 1, 1, 0, 0, 1);
        expectValue("restartScore", int'(bus.wave_score), 0);
        expectValue("restartAliens", int'(bus.aliens_left), 55);

        $display("[TB] ignored kills");
        applyStimulus("killRow6", 1, 0, 1, 6, 0);
        expectValue("row6Aliens", int'(bus.aliens_left), 55);
        applyStimulus("killRow7", 1, 0, 1, 7, 0);
        applyStimulus("plainLose", 1, 0, 0, 0, 1);
        applyStimulus("resetIdle", 0, 0, 0, 0, 0);
        applyStimulus("killIdle", 1, 0, 1, 0, 0);
        expectValue("idleKillScore", int'(bus.wave_score), 0);

        $display("[TB] reset on win edge");
        applyStimulus("startRst", 1, 1, 0, 0, 0);
        for (int i = 0; i < 54; i++) applyStimulus("preWin", 1, 0, 1, i / 11, 0);
        applyStimulus("resetAtWin", 0, 0, 1, 4, 0);
        expectValue("resetWin", int'(bus.win), 0);
        expectValue("resetScore", int'(bus.wave_score), 0);

        $display("[TB] random play");
        for (int n = 0; n < 1500; n++) begin
            bit rN;
            bit st;
            bit kl;
            bit ls;
            int row;
            rN  = ($urandom_range(0, 199) != 0);
            st  = ($urandom_range(0, 9) == 0);
            kl  = ($urandom_range(0, 1) == 1);
            ls  = ($urandom_range(0, 79) == 0);
            row = int'($urandom_range(0, 7));
            applyStimulus("random", rN, st, kl, row, ls);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_tally.md
WAVE_TALLY -- requirements
Module: wave_tally

Interface
REQ-001 The block SHALL have these ports, one clock and one reset, clock and reset first:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle pulse that begins a new wave.
- kill  input  1  one-cycle pulse: one alien destroyed.
- kill_row  input  3  row of the destroyed alien; 0 is the top row and 4 is the bottom row.
- lose  input  1  one-cycle pulse: player died or aliens reached the ground.
- wave_score  output  11  points earned in the current wave; maximum 1100.
- aliens_left  output  6  aliens remaining, 0..55.
- win  output  1  one-cycle pulse when the wave is cleared; the downstream score accumulator consumes it.
- active  output  1  high while the state is PLAY.

Function
REQ-002 The block SHALL implement a Moore FSM with four states:
- IDLE: no wave running.
- PLAY: wave in progress.
- WIN: wave cleared.
- OVER: wave lost.
REQ-003 Points per row SHALL be: row 0 = 30; rows 1–3 = 20; row 4 = 10.
- 11 columns per row, so a full wave scores exactly 1100 from 55 aliens.
REQ-004 IDLE or OVER with start=1 SHALL move to PLAY on the next edge, with aliens_left=55 and wave_score=0.
REQ-005 Start SHALL be ignored in PLAY and WIN.
REQ-006 In PLAY, kill=1 with kill_row ≤ 4 SHALL, at the next edge:
- add the row's points to wave_score;
- decrement aliens_left by 1.
Latency is one cycle.
REQ-007 A kill SHALL be ignored in these cases:
- kill_row is 5–7;
- the state is not PLAY;
- aliens_left is 0.
REQ-008 wave_score SHALL saturate at 1100 and never wrap; aliens_left SHALL never underflow.
REQ-009 A kill that takes aliens_left from 1 to 0 SHALL move to WIN on the same edge.
REQ-010 In WIN, the outputs SHALL be:
- win=1 for exactly one cycle;
- wave_score holds the final value, so the downstream adder sees the final score during the win cycle.
REQ-011 WIN SHALL go to IDLE unconditionally on the next edge; that same edge SHALL clear wave_score to 0, which prevents a double count in the downstream display sum.
REQ-012 In PLAY, lose=1 SHALL move to OVER on the next edge, with wave_score and aliens_left frozen.
- win is never asserted for a lost wave.
REQ-013 Simultaneous kill and lose in PLAY SHALL behave as follows:
- the kill is scored first;
- if it was the last alien, the state goes to WIN;
- otherwise it goes to OVER.
REQ-014 lose SHALL be ignored outside PLAY.
REQ-015 Simultaneous start and lose in OVER SHALL be treated as start.
REQ-016 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-017 active SHALL equal 1 exactly when the state is PLAY.

Reset
REQ-018 When reset_n=0 at a rising edge, the block SHALL set: state IDLE, wave_score=0, aliens_left=0, win=0, active=0.
REQ-019 Reset SHALL take priority over every input, including reset asserted mid-wave or during WIN.
- A win pulse in flight is cancelled.

Structure
REQ-020 A shared package invaders_pkg SHALL hold:
- the state enum type;
- ALIEN_ROWS=5, ALIEN_COLS=11, MAX_WAVE_SCORE=1100;
- the row-points constants 30/20/10.
REQ-021 The row-to-points lookup SHALL be a sub-module row_points: a combinational 3-bit row input giving a 6-bit points output and a valid flag.
REQ-022 The block SHALL contain no other sub-modules.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset then start → one cycle later aliens_left=55, wave_score=0, active=1.
- In PLAY: kill row 0, kill row 2, kill row 4 on consecutive cycles → wave_score reads 30, 50, 60, each one cycle after its kill; aliens_left ends at 52.
- Kill all 55 aliens (11 per row) → during the win cycle wave_score=1100 and aliens_left=0; win is high for exactly 1 cycle; next cycle state IDLE and wave_score=0.
- After 3 row-1 kills (wave_score=60), lose together with a row-1 kill → state OVER, wave_score=80, win never asserted; then start → PLAY with wave_score=0, aliens_left=55.
- kill_row=6 in PLAY, and kill while IDLE → no change to wave_score or aliens_left.
- reset_n=0 on the cycle a win would fire → win stays 0; all outputs read reset values next cycle.
